// File: rtl/inst_loader.sv
// Program loader: parses a framed byte stream (count, 9-bit words, checksum) into
// sequential instruction-memory writes and reports good/bad completion.
module inst_loader #(
    parameter int ADDR_W = 11,
    parameter int INST_W = 9
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              InValid,
    input  logic [7:0]        InData,
    output logic              InReady,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [INST_W-1:0] WrData,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [ADDR_W-1:0] WordsWritten
);
    localparam int CNT_HI_BITS = ADDR_W - 8;
    localparam int HI_BITS     = INST_W - 8;

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_INST_LO, S_INST_HI, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        lo_q, lo_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [INST_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              in_ready_q, busy_q, done_q, error_q;

    logic              accept;
    logic [7:0]        sum_acc;
    logic [ADDR_W-1:0] count_new;
    logic [ADDR_W-1:0] addr_inc;

    assign accept    = InValid && in_ready_q;
    assign sum_acc   = sum_q + InData;
    assign count_new = {InData[CNT_HI_BITS-1:0], lo_q};
    assign addr_inc  = addr_q + 1'b1;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path infers a latch.
        state_d   = state_q;
        sum_d     = sum_q;
        lo_d      = lo_q;
        count_d   = count_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (Start) begin
                    state_d = S_CNT_LO;
                    sum_d   = '0;
                    addr_d  = '0;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    sum_d   = sum_acc;
                    lo_d    = InData;
                    state_d = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    sum_d   = sum_acc;
                    count_d = count_new;
                    if ((InData >> CNT_HI_BITS) != '0) state_d = S_ERR;
                    else if (count_new == '0)          state_d = S_CHK;
                    else                               state_d = S_INST_LO;
                end
            end
            S_INST_LO: begin
                if (accept) begin
                    sum_d   = sum_acc;
                    lo_d    = InData;
                    state_d = S_INST_HI;
                end
            end
            S_INST_HI: begin
                if (accept) begin
                    sum_d = sum_acc;
                    if ((InData >> HI_BITS) != '0) begin
                        state_d = S_ERR;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = {InData[HI_BITS-1:0], lo_q};
                        addr_d    = addr_inc;
                        state_d   = (addr_inc == count_q) ? S_CHK : S_INST_LO;
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    sum_d   = sum_acc;
                    state_d = (sum_acc == 8'h00) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            sum_q      <= '0;
            lo_q       <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            lo_q       <= lo_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            // NOTE: status flags decode the next state so they switch on the same edge as the state.
            in_ready_q <= state_d inside {S_CNT_LO, S_CNT_HI, S_INST_LO, S_INST_HI, S_CHK};
            busy_q     <= !(state_d inside {S_IDLE, S_DONE, S_ERR});
            done_q     <= (state_d == S_DONE);
            error_q    <= (state_d == S_ERR);
        end
    end

    assign InReady      = in_ready_q;
    assign WrEn         = wr_en_q;
    assign WrAddr       = wr_addr_q;
    assign WrData       = wr_data_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Error        = error_q;
    assign WordsWritten = addr_q;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: a frame-position model predicts every output each
// cycle, and directed frames pin the model with hand-computed writes and flags.
module tb_inst_loader;
    localparam int ADDR_W = 11;
    localparam int INST_W = 9;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              Start = 1'b0;
    logic              InValid = 1'b0;
    logic [7:0]        InData = 8'h00;
    logic              InReady, WrEn, Busy, Done, Error;
    logic [ADDR_W-1:0] WrAddr, WordsWritten;
    logic [INST_W-1:0] WrData;

    always #5 Clk = ~Clk;

    inst_loader #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .InValid(InValid), .InData(InData),
        .InReady(InReady), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .Busy(Busy), .Done(Done), .Error(Error), .WordsWritten(WordsWritten)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tracks the byte position inside the current frame and derives outputs from it.
    bit                m_loading = 0;
    int                m_pos = 0;
    int                m_n = 0;
    logic [7:0]        m_lo = '0;
    logic [7:0]        m_sum = '0;
    logic [ADDR_W-1:0] m_words = '0;
    logic [ADDR_W-1:0] m_waddr = '0;
    logic [INST_W-1:0] m_wdata = '0;
    bit                m_wren = 0, m_done = 0, m_err = 0;
    logic [19:0]       wlog[$];

    always @(posedge Clk) begin
        if (!Reset) begin
            m_loading = 0; m_wren = 0; m_done = 0; m_err = 0;
            m_words = '0; m_waddr = '0; m_wdata = '0; m_sum = '0;
        end else begin
            m_wren = 0;
            if (!m_loading) begin
                if (Start) begin
                    m_loading = 1; m_pos = 0; m_sum = '0; m_words = '0;
                    m_done = 0; m_err = 0;
                end
            end else if (InValid) begin
                m_sum = 8'(m_sum + InData);
                if (m_pos == 0) begin
                    m_lo = InData; m_pos = 1;
                end else if (m_pos == 1) begin
                    if (InData[7:3] != 5'd0) begin
                        m_loading = 0; m_err = 1;
                    end else begin
                        m_n = int'({InData[2:0], m_lo}); m_pos = 2;
                    end
                end else if (m_pos == 2 + 2 * m_n) begin
                    m_loading = 0;
                    if (m_sum == 8'h00) m_done = 1; else m_err = 1;
                end else if (m_pos % 2 == 0) begin
                    m_lo = InData; m_pos++;
                end else if (InData[7:1] != 7'd0) begin
                    m_loading = 0; m_err = 1;
                end else begin
                    m_wren = 1; m_waddr = m_words; m_wdata = {InData[0], m_lo};
                    m_words = m_words + 1'b1; m_pos++;
                end
            end
        end
        #1;
        check("ready", 32'(InReady), 32'(m_loading));
        check("busy",  32'(Busy),    32'(m_loading));
        check("done",  32'(Done),    32'(m_done));
        check("error", 32'(Error),   32'(m_err));
        check("words", 32'(WordsWritten), 32'(m_words));
        check("wren",  32'(WrEn),    32'(m_wren));
        check("waddr", 32'(WrAddr),  32'(m_waddr));
        check("wdata", 32'(WrData),  32'(m_wdata));
        if (WrEn === 1'b1) wlog.push_back({WrAddr, WrData});
    end

    logic [7:0] frame[$];

    function automatic logic [31:0] log_at(input int i);
        if (i < wlog.size()) return 32'(wlog[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic do_start();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b, input int max_gap, input bit poke);
        int budget;
        repeat ($urandom_range(max_gap, 0)) begin
            InValid = 1'b0;
            if (poke && $urandom_range(2, 0) == 0) Start = 1'b1;
            @(negedge Clk);
            Start = 1'b0;
        end
        InValid = 1'b1;
        InData  = b;
        budget  = 20;
        while (InReady !== 1'b1 && budget > 0) begin
            @(negedge Clk);
            budget--;
        end
        if (budget == 0) check("ready_timeout", 32'(InReady), 32'd1);
        @(negedge Clk);
        InValid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap, input bit poke);
        foreach (frame[i]) put_byte(frame[i], max_gap, poke);
    endtask

    task automatic good_frame();
        frame = '{8'h02, 8'h00, 8'hA5, 8'h01, 8'h03, 8'h00, 8'h55};
    endtask

    task automatic check_good(input string tag);
        check({tag, "_nwr"},  32'(wlog.size()), 32'd2);
        check({tag, "_w0"},   log_at(0), 32'h0_01A5);
        check({tag, "_w1"},   log_at(1), 32'h0_0203);
        check({tag, "_done"}, 32'(Done), 32'd1);
        check({tag, "_err"},  32'(Error), 32'd0);
        check({tag, "_cnt"},  32'(WordsWritten), 32'd2);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] n;
        logic [7:0]  sum, hi, lo, cnt_hi;
        int          kind, bad_word;
        bit          cut;

        repeat (3) @(negedge Clk);
        check("rst_ready", 32'(InReady), 32'd0);
        check("rst_busy",  32'(Busy), 32'd0);
        check("rst_words", 32'(WordsWritten), 32'd0);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        // Good N=2 frame.
        wlog.delete(); good_frame(); do_start(); send_frame(0, 0);
        check_good("good");

        // Same frame, checksum off by one.
        wlog.delete(); good_frame(); frame[6] = 8'h54; do_start(); send_frame(0, 0);
        check("badsum_nwr",  32'(wlog.size()), 32'd2);
        check("badsum_err",  32'(Error), 32'd1);
        check("badsum_done", 32'(Done), 32'd0);

        // Empty frame.
        wlog.delete(); frame = '{8'h00, 8'h00, 8'h00}; do_start(); send_frame(0, 0);
        check("empty_nwr",  32'(wlog.size()), 32'd0);
        check("empty_done", 32'(Done), 32'd1);
        check("empty_cnt",  32'(WordsWritten), 32'd0);

        // Count high byte out of range.
        wlog.delete(); frame = '{8'h05, 8'h08}; do_start(); send_frame(0, 0);
        check("cnthi_err",   32'(Error), 32'd1);
        check("cnthi_ready", 32'(InReady), 32'd0);
        check("cnthi_nwr",   32'(wlog.size()), 32'd0);

        // Instruction high byte out of range.
        wlog.delete(); frame = '{8'h01, 8'h00, 8'h34, 8'h02}; do_start(); send_frame(0, 0);
        check("insthi_err", 32'(Error), 32'd1);
        check("insthi_nwr", 32'(wlog.size()), 32'd0);
        check("insthi_cnt", 32'(WordsWritten), 32'd0);

        // Stalled stream with Start poked while busy.
        for (int r = 0; r < 4; r++) begin
            wlog.delete(); good_frame(); do_start(); send_frame(5, 1);
            check_good("stall");
        end

        // Reset right after the first word is written.
        wlog.delete(); frame = '{8'h02, 8'h00, 8'hA5, 8'h01}; do_start(); send_frame(0, 0);
        check("mid_wren", 32'(WrEn), 32'd1);
        Reset = 1'b0;
        @(negedge Clk);
        check("mid_rst_busy",  32'(Busy), 32'd0);
        check("mid_rst_wren",  32'(WrEn), 32'd0);
        check("mid_rst_waddr", 32'(WrAddr), 32'd0);
        check("mid_rst_wdata", 32'(WrData), 32'd0);
        check("mid_rst_cnt",   32'(WordsWritten), 32'd0);
        check("mid_rst_ready", 32'(InReady), 32'd0);
        check("mid_nwr",       32'(wlog.size()), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        wlog.delete(); good_frame(); do_start(); send_frame(0, 0);
        check_good("after_rst");

        // Random frames: good, bad count, bad instruction high byte, bad checksum.
        for (int f = 0; f < 40; f++) begin
            n        = 11'($urandom_range(6, 0));
            kind     = int'($urandom_range(5, 0));
            bad_word = (n == 0) ? -1 : int'($urandom_range(int'(n) - 1, 0));
            cut      = 0;
            frame.delete();
            cnt_hi = {5'd0, n[10:8]};
            if (kind == 0) cnt_hi = cnt_hi | 8'(8'h08 << $urandom_range(4, 0));
            frame.push_back(n[7:0]);
            frame.push_back(cnt_hi);
            sum = 8'(n[7:0] + cnt_hi);
            if (kind == 0) cut = 1;
            for (int w = 0; w < int'(n) && !cut; w++) begin
                lo = 8'($urandom);
                hi = {7'd0, 1'($urandom)};
                if (kind == 1 && w == bad_word) begin
                    hi  = hi | 8'(8'h02 << $urandom_range(6, 0));
                    cut = 1;
                end
                frame.push_back(lo);
                frame.push_back(hi);
                sum = 8'(sum + lo + hi);
            end
            if (!cut) frame.push_back((kind == 2) ? 8'(-sum ^ 8'h01) : 8'(-sum));
            do_start();
            send_frame(3, 1);
            check("rand_done", 32'(Done), 32'((kind >= 3) || (kind == 1 && n == 0)));
            repeat ($urandom_range(2, 0)) @(negedge Clk);
        end

        repeat (2) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
